down_counter_reload: RTL and testbench
======================================

Name: down_counter_reload

Overview:
- Parameterised loadable down-counter, the counting-direction counterpart of the 5-bit up-counter testcase.
- Counts from a programmed reload value down to zero, then either auto-reloads or halts.
- Emits a registered terminal-count pulse and a sticky done flag.
- Used as an ArchBench testcase: the RTL is the golden model, and the bench compares it against its post-route netlist.

Parameters:
- WIDTH, 5, counter and load-value width in bits.
- RESET_VAL, {WIDTH{1'b1}} (31 for WIDTH=5), value loaded into out and reload_reg on reset.

Ports:
- clk  input  1  sole clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- en  input  1  count enable, sampled in RUN only.
- start  input  1  begin counting from reload_reg (IDLE/HALT only).
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value for out and reload_reg on load.
- auto_reload  input  1  1 = reload and continue at terminal count; 0 = halt.
- out  output  WIDTH  current count (registered).
- tc  output  1  one-cycle terminal-count pulse (registered).
- done  output  1  sticky: one-shot run finished.
- busy  output  1  high while state = RUN (decoded from state register).

Behaviour:
- Reset (reset=0, asynchronous, immediate, independent of clk):
  - out=RESET_VAL, reload_reg=RESET_VAL, state=IDLE, tc=0, done=0, busy=0.
  - Held for as long as reset=0; all inputs ignored.
- States: IDLE, RUN, HALT. All updates on rising clk edge. Per-edge priority: load > start > count.
- tc defaults to 0 every edge unless set by a terminal-count event below.
- load=1 (any state):
  - out<=load_val, reload_reg<=load_val, done<=0.
  - State: HALT→IDLE, RUN stays RUN, IDLE stays IDLE.
  - Same-cycle start and en are ignored; no decrement on a load edge.
- start=1, load=0, state IDLE or HALT:
  - out<=reload_reg, done<=0, state<=RUN.
  - The first decrement happens on the next edge with en=1.
  - start is ignored in RUN.
- RUN, load=0:
  - en=0: hold.
  - en=1, out!=0: out<=out-1.
  - en=1, out==0 (terminal count):
    - tc<=1 for exactly one cycle.
    - auto_reload=1: out<=reload_reg, stay RUN.
    - auto_reload=0: out holds 0, state<=HALT, done<=1.
- HALT: out=0, done=1, busy=0; en is ignored. Exits only on load (→IDLE), start (→RUN) or reset.
- IDLE: out holds its value; en is ignored.
- Arithmetic: unsigned WIDTH bits, no underflow below 0; the 0→reload transition is the only wrap.
- Loading 0 in RUN: the next en=1 edge is a terminal-count event (tc=1, reload or halt per auto_reload).
- auto_reload is sampled at the terminal-count edge only. Changing it mid-count takes effect at the next terminal count.
- Latency: an input change is visible on out/tc/done one edge later. busy follows state with no extra delay.
- Post-route equivalence: all outputs are registered or decoded from state, with no combinational input→output path. Golden and netlist must match exactly at every negedge sample.

Test Plan:
- Reset check: drive reset=0 mid-cycle.
  - Required: out=31, tc=0, done=0, busy=0 immediately, before the next clk edge.
  - Outputs stay there while reset=0, even with start=1 and load=1.
- Auto-reload wrap: release reset; pulse start; en=1, auto_reload=1 for 70 cycles.
  - Required: out 31,30,…,0,31,…; tc high exactly on the cycle after each out=0 edge (2 pulses); busy=1 throughout; done=0.
- One-shot: load load_val=5, start, en=1, auto_reload=0.
  - Required: out 5,4,3,2,1,0; one tc pulse; then HALT with done=1, busy=0.
  - out stays 0 for 10 further en=1 cycles; a later start → out=5, done=0, busy=1.
- Gated enable: in RUN from out=20, toggle en 1,0,0,1,1,0.
  - Required: out=19,19,19,18,17,17.
- Load/start collisions:
  - At out=17 in RUN, load=1, load_val=3 → out=3, still RUN; counts 2,1,0 then tc.
  - In IDLE, load=1 with start=1, load_val=9 → out=9, state IDLE, busy=0.
- Reset mid-run: assert reset at out=12, auto_reload=1.
  - Required: out=31, IDLE, reload_reg=31.
  - After release, en=1 without start → out stays 31; start → counting resumes from 31.
- Every scenario runs golden and post-route netlist side by side and requires zero mismatches.

Source files
------------

// File: rtl/down_counter_reload.sv
// Loadable down-counter with optional auto-reload at terminal count.
// Outputs are registered or decoded from the state register, so no input reaches an output combinationally.
module down_counter_reload #(
    parameter int               WIDTH     = 5,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            out_q    <= RESET_VAL;
            reload_q <= RESET_VAL;
            tc_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            done_q   <= done_d;
        end
    end

    // Priority per edge: load, then start, then counting.
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        done_d   = done_q;
        if (load) begin
            out_d    = load_val;
            reload_d = load_val;
            done_d   = 1'b0;
            if (state_q == HALT) begin
                state_d = IDLE;
            end
        end else if (start && (state_q != RUN)) begin
            out_d   = reload_q;
            done_d  = 1'b0;
            state_d = RUN;
        end else if ((state_q == RUN) && en) begin
            if (out_q != '0) begin
                out_d = out_q - WIDTH'(1);
            end else begin
                tc_d = 1'b1;
                if (auto_reload) begin
                    out_d = reload_q;
                end else begin
                    // Halting keeps out at zero.
                    state_d = HALT;
                    done_d  = 1'b1;
                end
            end
        end
    end

    assign out  = out_q;
    assign tc   = tc_q;
    assign done = done_q;
    assign busy = (state_q == RUN);

endmodule

// File: tb/tb_down_counter_reload.sv
// Directed bench for down_counter_reload: reset, auto-reload wrap, one-shot halt,
// gated enable, load/start collisions, zero load and reset mid-run.
module tb_down_counter_reload;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       start;
    logic       load;
    logic [4:0] load_val;
    logic       auto_reload;
    logic [4:0] out;
    logic       tc;
    logic       done;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    logic [4:0] exp_q[$];
    logic       exp_tc_q[$];

    down_counter_reload #(.WIDTH(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .start      (start),
        .load       (load),
        .load_val   (load_val),
        .auto_reload(auto_reload),
        .out        (out),
        .tc         (tc),
        .done       (done),
        .busy       (busy)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        checks++;
        if (out !== 5'd31 || {tc, done, busy} !== 3'b000) begin
            failures++;
            $display("FAIL power_on_reset: out=%0d tc/done/busy=%b exp out=31 flags=000", out, {tc, done, busy});
        end
        reset = 1'b1;
        load = 1'b1; load_val = 5'd7;
        step();
        load = 1'b0;
        checks++;
        if (out !== 5'd7) begin
            failures++;
            $display("FAIL reset_preload: out=%0d exp=7", out);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out !== 5'd31 || {tc, done, busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_async: out=%0d tc/done/busy=%b exp out=31 flags=000", out, {tc, done, busy});
        end
        start = 1'b1; load = 1'b1; load_val = 5'd4; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out !== 5'd31 || {tc, done, busy} !== 3'b000) begin
                failures++;
                $display("FAIL reset_hold[%0d]: out=%0d tc/done/busy=%b exp out=31 flags=000", i, out, {tc, done, busy});
            end
        end
        start = 1'b0; load = 1'b0; en = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_auto_reload();
        logic [4:0] e;
        logic       etc;
        logic [4:0] eo;
        int         pulses;
        auto_reload = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (out !== 5'd31 || busy !== 1'b1) begin
            failures++;
            $display("FAIL wrap_start: out=%0d busy=%b exp out=31 busy=1", out, busy);
        end
        e = 5'd31;
        for (int i = 0; i < 70; i++) begin
            if (e == 5'd0) begin
                e = 5'd31; etc = 1'b1;
            end else begin
                e = e - 5'd1; etc = 1'b0;
            end
            exp_q.push_back(e);
            exp_tc_q.push_back(etc);
        end
        pulses = 0;
        en = 1'b1;
        for (int i = 0; i < 70; i++) begin
            step();
            eo  = exp_q.pop_front();
            etc = exp_tc_q.pop_front();
            if (tc === 1'b1) pulses++;
            checks++;
            if (out !== eo || tc !== etc || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL wrap_cycle[%0d]: out=%0d tc=%b busy=%b done=%b exp out=%0d tc=%b busy=1 done=0",
                         i, out, tc, busy, done, eo, etc);
            end
        end
        en = 1'b0;
        checks++;
        if (pulses != 2) begin
            failures++;
            $display("FAIL wrap_tc_count: pulses=%0d exp=2", pulses);
        end
    endtask

    task automatic test_one_shot();
        load = 1'b1; load_val = 5'd5; auto_reload = 1'b0;
        step();
        load = 1'b0;
        checks++;
        if (out !== 5'd5 || busy !== 1'b1) begin
            failures++;
            $display("FAIL oneshot_load: out=%0d busy=%b exp out=5 busy=1", out, busy);
        end
        en = 1'b1;
        for (int k = 4; k >= 0; k--) begin
            step();
            checks++;
            if (out !== 5'(k) || tc !== 1'b0) begin
                failures++;
                $display("FAIL oneshot_count: out=%0d tc=%b exp out=%0d tc=0", out, tc, k);
            end
        end
        step();
        checks++;
        if (out !== 5'd0 || {tc, done, busy} !== 3'b110) begin
            failures++;
            $display("FAIL oneshot_tc: out=%0d tc/done/busy=%b exp out=0 flags=110", out, {tc, done, busy});
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (out !== 5'd0 || {tc, done, busy} !== 3'b010) begin
                failures++;
                $display("FAIL oneshot_halt[%0d]: out=%0d tc/done/busy=%b exp out=0 flags=010", i, out, {tc, done, busy});
            end
        end
        start = 1'b1;
        step();
        start = 1'b0; en = 1'b0;
        checks++;
        if (out !== 5'd5 || {tc, done, busy} !== 3'b001) begin
            failures++;
            $display("FAIL oneshot_restart: out=%0d tc/done/busy=%b exp out=5 flags=001", out, {tc, done, busy});
        end
    endtask

    task automatic test_gated_enable();
        logic       en_pat[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [4:0] exp_pat[6] = '{5'd19, 5'd19, 5'd19, 5'd18, 5'd17, 5'd17};
        load = 1'b1; load_val = 5'd20; auto_reload = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (out !== 5'd20 || busy !== 1'b1) begin
            failures++;
            $display("FAIL gate_load: out=%0d busy=%b exp out=20 busy=1", out, busy);
        end
        for (int i = 0; i < 6; i++) begin
            en = en_pat[i];
            step();
            checks++;
            if (out !== exp_pat[i]) begin
                failures++;
                $display("FAIL gate_step[%0d]: out=%0d exp=%0d", i, out, exp_pat[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_load_start_collision();
        load = 1'b1; load_val = 5'd3; en = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (out !== 5'd3 || busy !== 1'b1) begin
            failures++;
            $display("FAIL coll_run_load: out=%0d busy=%b exp out=3 busy=1", out, busy);
        end
        for (int k = 2; k >= 0; k--) begin
            step();
            checks++;
            if (out !== 5'(k) || tc !== 1'b0) begin
                failures++;
                $display("FAIL coll_count: out=%0d tc=%b exp out=%0d tc=0", out, tc, k);
            end
        end
        step();
        checks++;
        if (out !== 5'd3 || tc !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL coll_reload_tc: out=%0d tc=%b busy=%b exp out=3 tc=1 busy=1", out, tc, busy);
        end
        // Reach HALT, then leave it with a load that collides with start.
        auto_reload = 1'b0; load = 1'b1; load_val = 5'd1;
        step();
        load = 1'b0;
        step();
        step();
        en = 1'b0;
        checks++;
        if ({tc, done, busy} !== 3'b110) begin
            failures++;
            $display("FAIL coll_halt: tc/done/busy=%b exp 110", {tc, done, busy});
        end
        load = 1'b1; start = 1'b1; load_val = 5'd9;
        step();
        load = 1'b0; start = 1'b0;
        checks++;
        if (out !== 5'd9 || {tc, done, busy} !== 3'b000) begin
            failures++;
            $display("FAIL coll_idle_load: out=%0d tc/done/busy=%b exp out=9 flags=000", out, {tc, done, busy});
        end
        en = 1'b1;
        step();
        en = 1'b0;
        checks++;
        if (out !== 5'd9 || busy !== 1'b0) begin
            failures++;
            $display("FAIL coll_idle_en: out=%0d busy=%b exp out=9 busy=0", out, busy);
        end
    endtask

    task automatic test_load_zero();
        start = 1'b1;
        step();
        start = 1'b0;
        load = 1'b1; load_val = 5'd0;
        step();
        load = 1'b0;
        checks++;
        if (out !== 5'd0 || tc !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL zero_load: out=%0d tc=%b busy=%b exp out=0 tc=0 busy=1", out, tc, busy);
        end
        auto_reload = 1'b1; en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (out !== 5'd0 || tc !== 1'b1 || busy !== 1'b1) begin
                failures++;
                $display("FAIL zero_reload[%0d]: out=%0d tc=%b busy=%b exp out=0 tc=1 busy=1", i, out, tc, busy);
            end
        end
        auto_reload = 1'b0;
        step();
        en = 1'b0;
        checks++;
        if (out !== 5'd0 || {tc, done, busy} !== 3'b110) begin
            failures++;
            $display("FAIL zero_halt: out=%0d tc/done/busy=%b exp out=0 flags=110", out, {tc, done, busy});
        end
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1;
        step();
        start = 1'b0;
        load = 1'b1; load_val = 5'd12; auto_reload = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (out !== 5'd12 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre: out=%0d busy=%b exp out=12 busy=1", out, busy);
        end
        en = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out !== 5'd31 || {tc, done, busy} !== 3'b000) begin
            failures++;
            $display("FAIL midrst_async: out=%0d tc/done/busy=%b exp out=31 flags=000", out, {tc, done, busy});
        end
        en = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out !== 5'd31 || busy !== 1'b0) begin
                failures++;
                $display("FAIL midrst_idle[%0d]: out=%0d busy=%b exp out=31 busy=0", i, out, busy);
            end
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (out !== 5'd31 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_start: out=%0d busy=%b exp out=31 busy=1", out, busy);
        end
        step();
        step();
        en = 1'b0;
        checks++;
        if (out !== 5'd29) begin
            failures++;
            $display("FAIL midrst_resume: out=%0d exp=29", out);
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; start = 1'b0; load = 1'b0;
        load_val = 5'd0; auto_reload = 1'b0;
        test_reset();
        test_auto_reload();
        test_one_shot();
        test_gated_enable();
        test_load_start_collision();
        test_load_zero();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
